// File: rtl/inv_mat_vec.sv
// rtl/inv_mat_vec.sv - sequential 3x3 fixed-point matrix times vector, one MAC per cycle
module inv_mat_vec #(
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [W-1:0] Inv11,
  input  logic signed [W-1:0] Inv12,
  input  logic signed [W-1:0] Inv13,
  input  logic signed [W-1:0] Inv21,
  input  logic signed [W-1:0] Inv22,
  input  logic signed [W-1:0] Inv23,
  input  logic signed [W-1:0] Inv31,
  input  logic signed [W-1:0] Inv32,
  input  logic signed [W-1:0] Inv33,
  input  logic signed [W-1:0] B1,
  input  logic signed [W-1:0] B2,
  input  logic signed [W-1:0] B3,
  output logic                busy,
  output logic                done,
  output logic signed [W-1:0] X1,
  output logic signed [W-1:0] X2,
  output logic signed [W-1:0] X3,
  output logic                ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]     inv_q [9];
  logic signed [W-1:0]     b_q   [3];
  logic signed [W-1:0]     x_q   [3];
  logic signed [2*W+1:0]   acc_q;
  logic [1:0]              row_q, col_q;
  logic                    ovf_q, done_q;

  logic [3:0]              idx;
  logic signed [2*W-1:0]   op_a, op_b, prod;
  logic signed [2*W+1:0]   acc_sum, rnd_sum, shifted;
  logic signed [2*W+1:0]   max_v, min_v, rnd_v;
  logic signed [W-1:0]     sat_v;
  logic                    sat_hit;
  logic                    last_col;

  // Select the current matrix element, form the full-width product and the rounded, saturated row result
  always_comb begin
    idx     = ({2'b00, row_q} * 4'd3) + {2'b00, col_q};
    op_a    = (2*W)'(inv_q[idx]);
    op_b    = (2*W)'(b_q[col_q]);
    prod    = op_a * op_b;
    acc_sum = acc_q + (2*W+2)'(prod);
    rnd_v   = '0;
    rnd_v[FRAC-1] = 1'b1;
    rnd_sum = acc_sum + rnd_v;
    shifted = rnd_sum >>> FRAC;
    max_v   = '0;
    max_v[W-2:0] = '1;
    min_v   = '1;
    min_v[W-2:0] = '0;
    sat_hit = 1'b0;
    if (shifted > max_v) begin
      sat_v   = {1'b0, {(W-1){1'b1}}};
      sat_hit = 1'b1;
    end else if (shifted < min_v) begin
      sat_v   = {1'b1, {(W-1){1'b0}}};
      sat_hit = 1'b1;
    end else begin
      sat_v   = shifted[W-1:0];
    end
    last_col = (col_q == 2'd2);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; any unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last_col && (row_q == 2'd2)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, accumulation, row write-back and the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) inv_q[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        b_q[i] <= '0;
        x_q[i] <= '0;
      end
      acc_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            inv_q[0] <= Inv11; inv_q[1] <= Inv12; inv_q[2] <= Inv13;
            inv_q[3] <= Inv21; inv_q[4] <= Inv22; inv_q[5] <= Inv23;
            inv_q[6] <= Inv31; inv_q[7] <= Inv32; inv_q[8] <= Inv33;
            b_q[0]   <= B1;    b_q[1]   <= B2;    b_q[2]   <= B3;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
          end
        end
        S_MAC: begin
          if (last_col) begin
            x_q[row_q] <= sat_v;
            if (sat_hit) ovf_q <= 1'b1;
            acc_q <= '0;
            row_q <= row_q + 2'd1;
            col_q <= '0;
          end else begin
            acc_q <= acc_sum;
            col_q <= col_q + 2'd1;
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
          row_q  <= '0;
        end
        default: begin
          row_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

  // Status and result outputs
  always_comb begin
    busy = (state_q == S_MAC) || (state_q == S_DONE);
    done = done_q;
    ovf  = ovf_q;
    X1   = x_q[0];
    X2   = x_q[1];
    X3   = x_q[2];
  end

endmodule

// File: doc/inv_mat_vec.md
INV_MAT_VEC -- requirements
Module: inv_mat_vec

Interface
REQ-001 Parameter W, default 32, data word width in bits (signed).
REQ-002 Parameter FRAC, default 16, fractional bits of every data word (Q16.16 at defaults).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request to compute X = Inv * B; sampled only in IDLE.
REQ-006 Inv11..Inv33  input  W each (9 ports)  signed 3x3 matrix from the upstream inverse stage, row-major.
REQ-007 B1, B2, B3  input  W each  signed right-hand-side vector.
REQ-008 busy  output  1  high while a computation is in progress.
REQ-009 done  output  1  one-cycle pulse when X1..X3 are valid.
REQ-010 X1, X2, X3  output  W each  signed result vector, same Q format as the inputs.
REQ-011 ovf  output  1  at least one result element saturated in the last completed operation.

Function
REQ-012 States: IDLE, MAC, DONE; encoding is free.
REQ-013 IDLE with start=1 at an edge: latch all 12 inputs into internal registers, clear the accumulator, clear ovf, set row=0 and col=0, enter MAC.
REQ-014 Inputs are not sampled after the start edge; input changes during MAC do not affect results.
REQ-015 MAC: exactly 9 cycles, one product per cycle, order row-major (row 0..2 outer, col 0..2 inner).
REQ-016 Product: full 2W-bit signed Inv[row][col] * B[col], accumulated in a register of at least 2W+2 bits (no internal overflow).
REQ-017 At col=2: result = (acc + product + 2^(FRAC-1)) >>> FRAC (arithmetic shift, round half up), saturated to [-2^(W-1), 2^(W-1)-1], written to X[row+1]; accumulator cleared; row increments, col returns to 0.
REQ-018 Saturation in any row sets ovf; ovf is held until the next accepted start.
REQ-019 After the row-2/col-2 cycle, enter DONE; done=1 for exactly that one cycle; next state IDLE.
REQ-020 Latency: start sampled at edge k -> done high during the cycle after edge k+10; a new start is accepted at the earliest at edge k+11.
REQ-021 busy=1 in MAC and DONE, 0 in IDLE.
REQ-022 start while busy=1 is ignored and not queued.
REQ-023 X1..X3 update only as written in REQ-017 and otherwise hold; values from the previous operation stay visible until overwritten.
REQ-024 A partially written X (rows 0-1 updated, row 2 old) is permitted during MAC; consumers sample only on done.
REQ-025 Illegal or unused state encoding: return to IDLE on the next edge with busy=0 and done=0.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, busy=0, done=0, ovf=0, X1..X3=0, accumulator=0, row=col=0, regardless of current state.
REQ-027 Reset during MAC aborts the operation; no done pulse follows release.
REQ-028 First start is accepted at the first rising edge after rst_n deasserts.

Verification
REQ-029 Identity: Inv=I (diagonal 0x00010000), B=(0x00010000, 0x00020000, 0xFFFD0000), start at edge k -> done in cycle after edge k+10, X=(0x00010000, 0x00020000, 0xFFFD0000), ovf=0.
REQ-030 Rounding: Inv11=0x00000001, other entries 0, B1=0x00008000 -> X1=0x00000001, X2=X3=0; Inv11=0xFFFFFFFF, B1=0x00008000 -> X1=0x00000000.
REQ-031 Saturation: Inv11=0x7FFFFFFF, B1=0x00020000 -> X1=0x7FFFFFFF, ovf=1; Inv11=0x80000000, B1=0x00020000 -> X1=0x80000000, ovf=1; a following in-range operation -> ovf=0.
REQ-032 Full product: Inv rows (1,2,3),(4,5,6),(7,8,9) in Q16.16, B=(1,0,-1) -> X=(-2,-2,-2), i.e. 0xFFFE0000 each.
REQ-033 Start held high for 15 cycles, with inputs changed mid-MAC -> exactly one done, results from the inputs latched at the start edge, second start accepted at edge k+11.
REQ-034 rst_n pulsed low during MAC cycle 5 -> busy, done, ovf, X1..X3 go to 0 immediately; no done afterwards; a new start after release completes correctly.
